// File: rtl/decode_stage_pipe_if.sv
// ID-stage bus: IF/ID inputs, WB write port, stall request and ID/EX outputs.
interface decode_stage_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_valid;
    logic            flush_i;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall_o;
    logic            ex_valid;
    logic            ex_illegal;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [1:0]      ex_result_src;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic            ex_alu_src;
    logic            ex_branch;
    logic            ex_jump;
    logic [2:0]      ex_alu_control;

    modport master (
        output id_instr, id_pc, id_valid, flush_i, wb_we, wb_rd, wb_data,
        input  stall_o, ex_valid, ex_illegal, ex_rd1, ex_rd2, ex_imm, ex_pc,
               ex_rs1, ex_rs2, ex_rd, ex_result_src, ex_mem_write, ex_reg_write,
               ex_alu_src, ex_branch, ex_jump, ex_alu_control
    );

    modport slave (
        input  id_instr, id_pc, id_valid, flush_i, wb_we, wb_rd, wb_data,
        output stall_o, ex_valid, ex_illegal, ex_rd1, ex_rd2, ex_imm, ex_pc,
               ex_rs1, ex_rs2, ex_rd, ex_result_src, ex_mem_write, ex_reg_write,
               ex_alu_src, ex_branch, ex_jump, ex_alu_control
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I-subset decode stage: register file, decoder, immediates, load-use
// stall and ID/EX register. XLEN must match the interface instance's XLEN.
module decode_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_pipe_if.slave bus
);

    localparam int unsigned RIDX = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            reg_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [2:0]      alu_control;
    } ex_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [3:0]      alu_r;
    logic [3:0]      alu_i;
    logic            use_rs1;
    logic            use_rs2;
    logic            illegal;
    logic            stall;
    ex_t             dec;
    ex_t             ex_d;
    ex_t             ex_q;

    // True when idx addresses a physical register.
    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < 6'(NREGS);
    endfunction

    // funct3 to ALU op, returned as {legal, control}.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return {1'b1, (sub ? ALU_SUB : ALU_ADD)};
            3'b111:  return {1'b1, ALU_AND};
            3'b110:  return {1'b1, ALU_OR};
            3'b010:  return {1'b1, ALU_SLT};
            default: return 4'b0000;
        endcase
    endfunction

    assign opcode = bus.id_instr[6:0];
    assign funct3 = bus.id_instr[14:12];
    assign rs1    = bus.id_instr[19:15];
    assign rs2    = bus.id_instr[24:20];
    assign rd     = bus.id_instr[11:7];

    assign imm_i = {{(XLEN-12){bus.id_instr[31]}}, bus.id_instr[31:20]};
    assign imm_s = {{(XLEN-12){bus.id_instr[31]}}, bus.id_instr[31:25], bus.id_instr[11:7]};
    assign imm_b = {{(XLEN-13){bus.id_instr[31]}}, bus.id_instr[31], bus.id_instr[7],
                    bus.id_instr[30:25], bus.id_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){bus.id_instr[31]}}, bus.id_instr[31], bus.id_instr[19:12],
                    bus.id_instr[20], bus.id_instr[30:21], 1'b0};

    // Sub is only reachable from R-type; in I-type bit 30 belongs to the immediate.
    assign alu_r = alu_decode(funct3, bus.id_instr[30]);
    assign alu_i = alu_decode(funct3, 1'b0);

    // Register write port; x0 and unimplemented indices drop writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && bus.wb_rd != 5'd0 && in_range(bus.wb_rd)) begin
            regs[bus.wb_rd[RIDX-1:0]] <= bus.wb_data;
        end
    end

    // Read ports with same-cycle WB bypass.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0 && in_range(rs1)) begin
            rd1 = (bus.wb_we && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1[RIDX-1:0]];
        end
        if (rs2 != 5'd0 && in_range(rs2)) begin
            rd2 = (bus.wb_we && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2[RIDX-1:0]];
        end
    end

    // Control decode and immediate select for the instruction in ID.
    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        illegal     = 1'b0;
        dec.valid   = 1'b1;
        dec.pc      = bus.id_pc;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.rd      = rd;
        dec.rd1     = rd1;
        dec.rd2     = rd2;
        case (opcode)
            OP_LW: begin
                use_rs1         = 1'b1;
                dec.result_src  = 2'b01;
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_i;
                illegal         = (funct3 != 3'b010);
            end
            OP_SW: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec.mem_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm         = imm_s;
                illegal         = (funct3 != 3'b010);
            end
            OP_R: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_control = alu_r[2:0];
                illegal         = !alu_r[3];
            end
            OP_I: begin
                use_rs1         = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = alu_i[2:0];
                dec.imm         = imm_i;
                illegal         = !alu_i[3];
            end
            OP_BEQ: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                dec.imm         = imm_b;
                illegal         = (funct3 != 3'b000);
            end
            OP_JAL: begin
                dec.result_src  = 2'b10;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.imm         = imm_j;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            dec.illegal     = 1'b1;
            dec.result_src  = 2'b00;
            dec.mem_write   = 1'b0;
            dec.reg_write   = 1'b0;
            dec.alu_src     = 1'b0;
            dec.branch      = 1'b0;
            dec.jump        = 1'b0;
            dec.alu_control = ALU_ADD;
            dec.imm         = '0;
        end
    end

    // Load-use hazard: only from registered EX state and the instruction in ID.
    always_comb begin
        stall = 1'b0;
        if (!rst && bus.id_valid && ex_q.valid && ex_q.result_src == 2'b01 && ex_q.rd != 5'd0) begin
            stall = (use_rs1 && ex_q.rd == rs1) || (use_rs2 && ex_q.rd == rs2);
        end
    end

    // Next ID/EX contents: flush, stall and empty slot all insert a bubble.
    always_comb begin
        ex_d = dec;
        if (bus.flush_i || stall || !bus.id_valid) begin
            ex_d = '0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_illegal     = ex_q.illegal;
    assign bus.ex_rd1         = ex_q.rd1;
    assign bus.ex_rd2         = ex_q.rd2;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_rs1         = ex_q.rs1;
    assign bus.ex_rs2         = ex_q.rs2;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_result_src  = ex_q.result_src;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_alu_src     = ex_q.alu_src;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_alu_control = ex_q.alu_control;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed steps from the test plan, then a
// random instruction stream checked against an instruction-level model.
module tb_decode_stage_pipe;

    typedef enum int { K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL } kind_t;

    // What the generator intended: the model works from this, not from bits.
    typedef struct {
        logic [31:0] instr;
        kind_t       kind;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        int          imm;
        logic [2:0]  alu;
    } gen_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  rsrc;
        logic        mw;
        logic        rw;
        logic        asrc;
        logic        br;
        logic        jmp;
        logic [2:0]  alu;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mregs [32];
    ex_t  m_ex;

    decode_stage_pipe_if #(.XLEN(32)) bus ();

    decode_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    function automatic gen_t mk(input kind_t k, input logic [31:0] instr, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [4:0] d, input int imm,
                                input logic [2:0] alu);
        gen_t g;
        g.kind = k; g.instr = instr; g.rs1 = s1; g.rs2 = s2; g.rd = d; g.imm = imm; g.alu = alu;
        return g;
    endfunction

    function automatic logic uses1(input kind_t k);
        return k inside {K_LW, K_SW, K_R, K_I, K_BEQ};
    endfunction

    function automatic logic uses2(input kind_t k);
        return k inside {K_R, K_SW, K_BEQ};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
        if (we && wrd == idx) return wdata;
        return mregs[idx];
    endfunction

    // Expected ID/EX contents plus a mask of the fields the instruction defines.
    task automatic model_expect(input gen_t g, input logic [31:0] pc, input logic we,
                                input logic [4:0] wrd, input logic [31:0] wdata,
                                output ex_t e, output ex_t m);
        e = '0; m = '0;
        e.valid = 1'b1;
        m.valid = 1'b1; m.illegal = 1'b1; m.rw = 1'b1; m.mw = 1'b1; m.br = 1'b1; m.jmp = 1'b1;
        if (g.kind == K_ILL) begin
            e.illegal = 1'b1;
            return;
        end
        m.imm = '1; m.pc = '1; m.rsrc = '1;
        e.imm = 32'(g.imm);
        e.pc  = pc;
        case (g.kind)
            K_LW:    begin e.rsrc = 2'b01; e.rw = 1'b1; e.asrc = 1'b1; e.alu = 3'b000; end
            K_SW:    begin e.mw = 1'b1; e.asrc = 1'b1; e.alu = 3'b000; end
            K_R:     begin e.rw = 1'b1; e.asrc = 1'b0; e.alu = g.alu; end
            K_I:     begin e.rw = 1'b1; e.asrc = 1'b1; e.alu = g.alu; end
            K_BEQ:   begin e.br = 1'b1; e.asrc = 1'b0; e.alu = 3'b001; end
            default: begin e.rsrc = 2'b10; e.rw = 1'b1; e.jmp = 1'b1; end
        endcase
        if (g.kind != K_JAL) begin
            m.asrc = 1'b1; m.alu = '1;
        end
        if (uses1(g.kind)) begin
            m.rs1 = '1; m.rd1 = '1; e.rs1 = g.rs1; e.rd1 = model_read(g.rs1, we, wrd, wdata);
        end
        if (uses2(g.kind)) begin
            m.rs2 = '1; m.rd2 = '1; e.rs2 = g.rs2; e.rd2 = model_read(g.rs2, we, wrd, wdata);
        end
        if (e.rw) begin
            m.rd = '1; e.rd = g.rd;
        end
    endtask

    function automatic logic model_stall(input gen_t g, input logic valid);
        if (!(valid && m_ex.valid && m_ex.rsrc == 2'b01 && m_ex.rd != 5'd0)) return 1'b0;
        return (uses1(g.kind) && m_ex.rd == g.rs1) || (uses2(g.kind) && m_ex.rd == g.rs2);
    endfunction

    function automatic ex_t observe();
        ex_t o;
        o.valid = bus.ex_valid;   o.illegal = bus.ex_illegal;
        o.rd1 = bus.ex_rd1;       o.rd2 = bus.ex_rd2;
        o.imm = bus.ex_imm;       o.pc = bus.ex_pc;
        o.rs1 = bus.ex_rs1;       o.rs2 = bus.ex_rs2;       o.rd = bus.ex_rd;
        o.rsrc = bus.ex_result_src;
        o.mw = bus.ex_mem_write;  o.rw = bus.ex_reg_write;  o.asrc = bus.ex_alu_src;
        o.br = bus.ex_branch;     o.jmp = bus.ex_jump;      o.alu = bus.ex_alu_control;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input ex_t o, input ex_t e, input ex_t m);
        checks++;
        assert ((o & m) === (e & m))
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, o & m, e & m, m);
        end
    endtask

    // One clock: drive, check stall before the edge, check ID/EX after it.
    task automatic cycle(input gen_t g, input logic [31:0] pc, input logic valid,
                         input logic flush, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wdata, output logic stalled);
        ex_t e, m;
        logic s;
        bus.id_instr = g.instr; bus.id_pc = pc; bus.id_valid = valid; bus.flush_i = flush;
        bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wdata;
        #1;
        s = model_stall(g, valid);
        chk("stall_o", 64'(bus.stall_o), 64'(s));
        if (flush || s || !valid) begin
            e = '0; m = '1;
        end else begin
            model_expect(g, pc, we, wrd, wdata, e, m);
        end
        if (we && wrd != 5'd0) mregs[wrd] = wdata;
        @(posedge clk);
        #1;
        m_ex = e;
        chk_ex("ex_bundle", observe(), e, m);
        stalled = s;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        logic st;
        cycle(mk(K_ILL, 32'h0000007F, 5'd0, 5'd0, 5'd0, 0, 3'b000), 32'd0, 1'b0, 1'b0,
              1'b1, r, d, st);
    endtask

    function automatic gen_t rand_gen();
        gen_t g;
        logic [2:0] r_f3  [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        logic [6:0] r_f7  [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [2:0] r_alu [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        logic [2:0] i_f3  [4] = '{3'b000, 3'b111, 3'b110, 3'b010};
        logic [2:0] i_alu [4] = '{3'b000, 3'b010, 3'b011, 3'b101};
        logic [6:0] bad_op [7] = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h0F, 7'h00};
        int k, op;
        logic [31:0] w;
        k = int'($urandom_range(0, 6));
        g.rs1 = 5'($urandom_range(0, 7));
        g.rs2 = 5'($urandom_range(0, 7));
        g.rd  = 5'($urandom_range(0, 7));
        g.imm = 0;
        g.alu = 3'b000;
        case (k)
            0: begin
                g.kind = K_LW; g.imm = int'($urandom_range(0, 4095)) - 2048;
                g.instr = enc_i(12'(g.imm), g.rs1, 3'b010, g.rd, 7'b0000011);
            end
            1: begin
                g.kind = K_SW; g.imm = int'($urandom_range(0, 4095)) - 2048;
                g.instr = enc_s(12'(g.imm), g.rs2, g.rs1);
            end
            2: begin
                g.kind = K_R; op = int'($urandom_range(0, 4)); g.alu = r_alu[op];
                g.instr = enc_r(r_f7[op], g.rs2, g.rs1, r_f3[op], g.rd);
            end
            3: begin
                g.kind = K_I; op = int'($urandom_range(0, 3)); g.alu = i_alu[op];
                g.imm = int'($urandom_range(0, 4095)) - 2048;
                g.instr = enc_i(12'(g.imm), g.rs1, i_f3[op], g.rd, 7'b0010011);
            end
            4: begin
                g.kind = K_BEQ; g.imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                g.instr = enc_b(13'(g.imm), g.rs2, g.rs1);
            end
            5: begin
                g.kind = K_JAL; g.imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                g.instr = enc_j(21'(g.imm), g.rd);
            end
            default: begin
                g.kind = K_ILL; w = $urandom();
                g.instr = {w[31:7], bad_op[$urandom_range(0, 6)]};
            end
        endcase
        return g;
    endfunction

    initial begin
        gen_t g_sub, g_lw5, g_use5, g_lw0, g_use0, g_rd5, g_byp, g_rdx0, g_ill, g_jal, g_badf3, g;
        logic st, fl, v, we;
        logic [31:0] pc;
        logic [4:0] wrd;

        g_sub  = mk(K_R, 32'h40320233, 5'd4, 5'd3, 5'd4, 0, 3'b001);
        g_lw5  = mk(K_LW, enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011), 5'd1, 5'd0, 5'd5, 0, 3'b000);
        g_use5 = mk(K_R, enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6), 5'd5, 5'd2, 5'd6, 0, 3'b000);
        g_lw0  = mk(K_LW, enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 5'd1, 5'd0, 5'd0, 0, 3'b000);
        g_use0 = mk(K_R, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6), 5'd0, 5'd0, 5'd6, 0, 3'b000);
        g_rd5  = mk(K_R, enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 5'd5, 5'd0, 5'd6, 0, 3'b000);
        g_byp  = mk(K_R, enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd7), 5'd3, 5'd0, 5'd7, 0, 3'b000);
        g_rdx0 = mk(K_R, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd7), 5'd0, 5'd0, 5'd7, 0, 3'b000);
        g_ill  = mk(K_ILL, 32'h0000007F, 5'd0, 5'd0, 5'd0, 0, 3'b000);
        g_jal  = mk(K_JAL, enc_j(21'd16, 5'd1), 5'd0, 5'd0, 5'd1, 16, 3'b000);
        g_badf3 = mk(K_ILL, enc_i(12'd0, 5'd1, 3'b000, 5'd5, 7'b0000011), 5'd0, 5'd0, 5'd0, 0, 3'b000);

        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_ex = '0;
        rst = 1'b1;
        bus.id_instr = 32'd0; bus.id_pc = 32'd0; bus.id_valid = 1'b0; bus.flush_i = 1'b0;
        bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        #1;
        chk_ex("reset_ex_zero", observe(), '0, '1);
        chk("reset_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset mid-stall clears ID/EX and the register file.
        wb_write(5'd5, 32'd7);
        cycle(g_lw5, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        bus.id_instr = g_use5.instr; bus.id_pc = 32'h104; bus.id_valid = 1'b1;
        #1;
        chk("pre_reset_stall", 64'(bus.stall_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_ex("async_reset_ex_zero", observe(), '0, '1);
        chk("reset_held_stall", 64'(bus.stall_o), 64'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_ex = '0;
        @(posedge clk);
        #1;
        chk("reset_held_valid", 64'(bus.ex_valid), 64'd0);
        rst = 1'b0;
        cycle(g_use5, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("held_instr_issues", 64'(bus.ex_valid), 64'd1);
        cycle(g_rd5, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("x5_after_reset", 64'(bus.ex_rd1), 64'd0);

        // R-type sub.
        wb_write(5'd4, 32'd9);
        wb_write(5'd3, 32'd4);
        cycle(g_sub, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("sub_rd1", 64'(bus.ex_rd1), 64'd9);
        chk("sub_rd2", 64'(bus.ex_rd2), 64'd4);
        chk("sub_alu", 64'(bus.ex_alu_control), 64'd1);
        chk("sub_rw", 64'(bus.ex_reg_write), 64'd1);
        chk("sub_asrc", 64'(bus.ex_alu_src), 64'd0);
        chk("sub_rd", 64'(bus.ex_rd), 64'd4);

        // Immediates.
        cycle(mk(K_I, 32'hFFF00093, 5'd0, 5'd0, 5'd1, -1, 3'b000), 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("addi_imm", 64'(bus.ex_imm), 64'hFFFF_FFFF);
        chk("addi_asrc", 64'(bus.ex_alu_src), 64'd1);
        cycle(mk(K_SW, 32'h0010A423, 5'd1, 5'd1, 5'd0, 8, 3'b000), 32'h208, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("sw_imm", 64'(bus.ex_imm), 64'd8);
        chk("sw_mw", 64'(bus.ex_mem_write), 64'd1);
        cycle(mk(K_BEQ, 32'h00100463, 5'd0, 5'd1, 5'd0, 8, 3'b001), 32'h20C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("beq_imm", 64'(bus.ex_imm), 64'd8);
        chk("beq_br", 64'(bus.ex_branch), 64'd1);
        chk("beq_alu", 64'(bus.ex_alu_control), 64'd1);
        cycle(g_jal, 32'h210, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("jal_imm", 64'(bus.ex_imm), 64'd16);
        chk("jal_rsrc", 64'(bus.ex_result_src), 64'd2);

        // Load-use stall for one cycle, then the held add issues.
        cycle(g_lw5, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        cycle(g_use5, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
        cycle(g_use5, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lu_issue_valid", 64'(bus.ex_valid), 64'd1);
        chk("lu_issue_rd", 64'(bus.ex_rd), 64'd6);
        cycle(g_lw0, 32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        cycle(g_use0, 32'h30C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lw_x0_no_stall", 64'(bus.ex_valid), 64'd1);

        // Bypass and x0 writes.
        cycle(g_byp, 32'h400, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000ABCD, st);
        chk("bypass_rd1", 64'(bus.ex_rd1), 64'h0000ABCD);
        wb_write(5'd0, 32'd5);
        cycle(g_rdx0, 32'h404, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("x0_read", 64'(bus.ex_rd1), 64'd0);

        // Flush with a stall pending, then illegal encodings.
        cycle(g_lw5, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        cycle(g_use5, 32'h504, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, st);
        chk("flush_bubble", 64'(bus.ex_valid), 64'd0);
        cycle(g_ill, 32'h508, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("ill_valid", 64'(bus.ex_valid), 64'd1);
        chk("ill_flag", 64'(bus.ex_illegal), 64'd1);
        chk("ill_rw", 64'(bus.ex_reg_write), 64'd0);
        cycle(g_badf3, 32'h50C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        chk("lw_badf3_illegal", 64'(bus.ex_illegal), 64'd1);

        // Random stream; upstream holds the instruction while stalled.
        pc = 32'h1000;
        st = 1'b0;
        fl = 1'b0;
        v  = 1'b1;
        g  = rand_gen();
        for (int i = 0; i < 500; i++) begin
            if (!(st && !fl)) begin
                g  = rand_gen();
                pc = pc + 32'd4;
                v  = ($urandom_range(0, 9) != 0);
            end
            fl  = ($urandom_range(0, 11) == 0);
            we  = 1'($urandom_range(0, 1));
            wrd = 5'($urandom_range(0, 7));
            cycle(g, pc, v, fl, we, wrd, $urandom(), st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised RV32I-subset instruction-decode stage for the pipelined core: integer register file, control decoder, immediate generator, load-use hazard detector and the ID/EX pipeline register in one block. It sits between the IF/ID register and the execute stage. It accepts the write-back port from the WB stage with same-cycle bypass. It emits registered operands and controls one cycle after the instruction is presented.

## Interface
- XLEN, 32, datapath width; immediates and register data are sign-extended/stored at this width (≥32).
- NREGS, 32, number of architectural registers (power of 2, 2..32); indices ≥ NREGS read as 0 and ignore writes.
- clk  in  1  stage clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_instr  in  32  instruction from IF/ID.
- id_pc  in  XLEN  PC of id_instr.
- id_valid  in  1  id_instr is a real instruction (0 = bubble).
- flush_i  in  1  branch/jump taken in EX: kill the instruction in ID.
- wb_we, wb_rd, wb_data  in  1/5/XLEN  register-file write port from WB.
- stall_o  out  1  combinational load-use stall request to PC and IF/ID (hold).
- ex_valid, ex_illegal  out  1/1  registered instruction valid / unsupported-encoding flag.
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  XLEN each  registered operands, extended immediate, PC.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices (for EX forwarding).
- ex_result_src  out  2  00 ALU, 01 memory, 10 PC+4.
- ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump  out  1 each.
- ex_alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

## Operation
- Opcodes: 0000011 lw, 0100011 sw, 0110011 R-ALU, 0010011 I-ALU, 1100011 beq, 1101111 jal. Any other opcode -> illegal.
- Controls: lw {rs=01, rw=1, asrc=1, add}; sw {mw=1, asrc=1, add}; R {rw=1, asrc=0}; I {rw=1, asrc=1}; beq {branch=1, asrc=0, sub}; jal {rs=10, rw=1, jump=1}.
- ALU funct3 (R/I): 000 add; in R-type only, 000 with funct7[5]=1 -> sub. 111 and, 110 or, 010 slt. Other funct3 -> illegal. lw/sw require funct3=010; beq requires funct3=000; otherwise illegal.
- Immediates, sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0.
- Register file:
  - x0 reads 0 and writes to x0 are dropped.
  - Write at clk edge when wb_we.
  - Read bypass: if wb_we && wb_rd==rs && rs!=0, the read returns wb_data in the same cycle.
- Load-use hazard: stall_o = id_valid && ex_valid && ex_result_src==01 && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).
  - rs1 is used by all supported formats except jal.
  - rs2 is used by R, sw and beq only.
- Bubble = ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_branch, ex_jump all 0. All other ex_* fields 0.
- Clock-edge update priority: flush_i -> bubble; else stall_o -> bubble; else !id_valid -> bubble; else load the decoded instruction.
- An illegal instruction loads ex_valid=1, ex_illegal=1 with all write/branch/jump controls 0.

## Timing
- Latency 1: instruction at edge n -> ex_* valid after edge n.
- stall_o depends on current ex_* and id_instr only. No combinational path from flush_i or wb_* to stall_o.
- Upstream must hold id_instr/id_pc while stall_o=1. The held instruction issues on the next edge, since the bubble clears the hazard.
- WB write and ID read of the same register in the same cycle: ID sees the new data (bypass), and the register is updated at the edge.
- rst asserted: all ex_* = 0 and all registers = 0 immediately, with no clock required. stall_o = 0 while reset is held.
- Reset mid-stall discards the held instruction's bubble state. First decode is at the first edge after rst deasserts.

## Test plan
- Reset: preload x5=7, assert rst asynchronously between edges -> ex_* all 0 at once; later read x5 -> 0.
- R-type: preload x4=9, x3=4, instr 0x40320233 (sub x4,x4,x3) -> next cycle ex_rd1=9, ex_rd2=4, ex_alu_control=001, ex_reg_write=1, ex_alu_src=0, ex_rd=4.
- I/S/B immediates:
  - addi x1,x0,-1 (0xFFF00093) -> ex_imm=0xFFFFFFFF, ex_alu_src=1.
  - sw x1,8(x1) -> ex_imm=8, ex_mem_write=1.
  - beq 0x0010_0463 -> ex_imm=8, ex_branch=1, ex_alu_control=001.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> stall_o=1 for one cycle, ex_valid=0 bubble, then add issues. lw x0 followed by a use of x0 -> no stall.
- Bypass: wb_we=1, wb_rd=3, wb_data=0xABCD in the same cycle as a read of x3 -> ex_rd1=0xABCD. A write to x0 with data 5 -> later read returns 0.
- flush_i=1 with a valid instr while a stall is also pending -> bubble. Opcode 0x7F -> ex_valid=1, ex_illegal=1, ex_reg_write=0.
